// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and the first-set-at-or-after-pointer round-robin search.
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int RR_MAX_REQ  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } arb_state_e;

  // One-hot of the first set bit of req at or after ptr, wrapping at n.
  function automatic logic [RR_MAX_REQ-1:0] rr_next(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [2:0]            ptr,
    input int                    n
  );
    logic [RR_MAX_REQ-1:0] gnt;
    logic                  found;
    int                    idx;
    gnt   = {RR_MAX_REQ{1'b0}};
    found = 1'b0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      idx = (idx >= n) ? idx - n : idx;
      if ((k < n) && !found && req[idx[2:0]]) begin
        gnt[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin picker with a registered pointer and registered one-hot grant.
// The pointer only moves on release, stepping just past the owner.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               pick_i,
  input  logic               release_i,
  output logic [NUM_REQ-1:0] grant_o
);
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [2:0]            ptr_q, ptr_d;
  logic [RR_MAX_REQ-1:0] req_ext_s, pick_s;
  logic [2:0]            owner_s;

  assign req_ext_s = RR_MAX_REQ'(req_i);
  assign pick_s    = rr_next(req_ext_s, ptr_q, NUM_REQ);

  // Encode the one-hot owner so the pointer can step past it.
  always_comb begin
    owner_s = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_s = 3'(i);
      end else begin
        owner_s = owner_s;
      end
    end
  end

  // Grant and pointer next state.
  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (release_i) begin
      grant_d = {NUM_REQ{1'b0}};
      ptr_d   = (owner_s == 3'(NUM_REQ - 1)) ? 3'd0 : owner_s + 3'd1;
    end else if (pick_i) begin
      grant_d = NUM_REQ'(pick_s);
    end else begin
      grant_d = grant_q;
    end
  end

  // Grant and pointer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q <= {NUM_REQ{1'b0}};
      ptr_q   <= 3'd0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_o = grant_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin sharing of one UART transmitter among NUM_REQ byte streams.
// Define ARB_TIMEOUT_EN to force release of an owner that stalls inside a message.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [UART_BYTE_W-1:0]         tx_data_o,
  output logic                           tx_start_o,
  input  logic                           tx_busy_i,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           err_timeout_o
);
  if ((NUM_REQ < 2) || (NUM_REQ > RR_MAX_REQ) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_s, ready_s;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d, sel_data_s;
  logic                   last_q, last_d, sel_last_s;
  logic                   tx_start_q, tx_start_d;
  logic                   err_timeout_q;
  logic                   hs_s, pick_s, release_s, timeout_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_valid_i),
    .pick_i    (pick_s),
    .release_i (release_s),
    .grant_o   (grant_s)
  );

  // Mux the owner's byte and last flag.
  always_comb begin
    sel_data_s = {UART_BYTE_W{1'b0}};
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        sel_data_s = req_data_i[UART_BYTE_W*i +: UART_BYTE_W];
        sel_last_s = req_last_i[i];
      end else begin
        sel_data_s = sel_data_s;
        sel_last_s = sel_last_s;
      end
    end
  end

  assign hs_s = (state_q == ST_LOAD) && (|(req_valid_i & grant_s));

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Stall counter: runs only while the owner withholds a byte in LOAD.
  always_comb begin
    tmo_cnt_d = {CNT_W{1'b0}};
    timeout_s = 1'b0;
    if ((state_q == ST_LOAD) && !hs_s) begin
      if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        timeout_s = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
    end else begin
      tmo_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_cnt_q <= {CNT_W{1'b0}};
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register and registered UART-side outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      tx_data_q     <= 8'h00;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      err_timeout_q <= timeout_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      state_d = (!tx_busy_i && (|req_valid_i)) ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (hs_s) begin
          state_d = ST_START;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: state_d = tx_busy_i ? ST_WAIT_DONE : ST_WAIT_BUSY;
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_d = last_q ? ST_IDLE : ST_LOAD;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output / control decode; tx_start is registered so it lands in the START cycle.
  always_comb begin
    ready_s    = {NUM_REQ{1'b0}};
    pick_s     = 1'b0;
    release_s  = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE:      pick_s = !tx_busy_i && (|req_valid_i);
      ST_LOAD: begin
        ready_s = req_valid_i & grant_s;
        if (hs_s) begin
          tx_start_d = 1'b1;
          tx_data_d  = sel_data_s;
          last_d     = sel_last_s;
        end else begin
          release_s = timeout_s;
        end
      end
      ST_WAIT_DONE: release_s = !tx_busy_i && last_q;
      default:      release_s = 1'b0;
    endcase
  end

  assign req_ready_o   = ready_s;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign grant_o       = grant_s;
  assign err_timeout_o = err_timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed latency/boundary steps plus randomized
// message traffic checked against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N     = 3;
  localparam int FRAME = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic [7:0]     tx_data;
  logic           tx_start, tx_busy, err_timeout;

  int          n_checks = 0;
  int          n_errors = 0;
  int          busy_cnt = 0;
  int          cyc      = 0;
  int          n_starts = 0;
  int          model_ptr = 0;
  logic [8:0]  rq [N][$];
  logic [10:0] exp_q [$];
  logic [N-1:0] in_msg = '0;
  logic [N-1:0] ready_seen = '0;
  logic [7:0]  cur_byte = 8'h00;
  logic        stable_en = 1'b0;
  logic        gaps_en = 1'b0;
  logic        tmo_phase = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_last_i    (req_last),
    .req_ready_o   (req_ready),
    .tx_data_o     (tx_data),
    .tx_start_o    (tx_start),
    .tx_busy_i     (tx_busy),
    .grant_o       (grant),
    .err_timeout_o (err_timeout)
  );

  always #5 clk = ~clk;

  // UART model: busy for FRAME cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    if (tx_start === 1'b1) busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Whole queued messages, served round-robin from model_ptr, one message per grant.
  task automatic model_build();
    logic [8:0] c [N][$];
    logic [8:0] b;
    int j;
    bit any;
    for (int i = 0; i < N; i++) c[i] = rq[i];
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (model_ptr + k) % N;
        if (!any && c[j].size() > 0) begin
          any = 1'b1;
          do begin
            b = c[j].pop_front();
            exp_q.push_back({3'(j), b[7:0]});
          end while (!b[8] && c[j].size() > 0);
          model_ptr = (j + 1) % N;
        end
      end
    end
  endtask

  task automatic step();
    logic [10:0] e;
    logic [8:0]  h;
    @(negedge clk);
    cyc++;
    chk("ready_within_grant", 32'(req_ready & ~grant), 32'd0);
    chk("ready_within_valid", 32'(req_ready & ~req_valid), 32'd0);
    chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    if (!tmo_phase) chk("err_timeout_quiet", 32'(err_timeout), 32'd0);
    if (tx_start === 1'b1) begin
      n_starts++;
      chk("start_bus_idle", 32'(tx_busy), 32'd0);
      chk("start_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("start_data", 32'(tx_data), 32'(e[7:0]));
        chk("start_grant", 32'(grant), 32'(1) << e[10:8]);
        cur_byte  = e[7:0];
        stable_en = 1'b1;
      end
    end else if (tx_busy && stable_en) begin
      chk("data_stable", 32'(tx_data), 32'(cur_byte));
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !(gaps_en && in_msg[i] && $urandom_range(3) == 0)) begin
        h = rq[i][0];
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = h[7:0];
        req_last[i]       = h[8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]       = 1'($urandom);
      end
    end
    #1;
    ready_seen = req_ready;
    if (reset !== 1'b1) begin
      for (int i = 0; i < N; i++) begin
        if (ready_seen[i] && rq[i].size() > 0) begin
          h = rq[i].pop_front();
          in_msg[i] = !h[8];
        end
      end
    end
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    in_msg    = '0;
    stable_en = 1'b0;
    model_ptr = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_env();
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || grant != '0 || tx_busy) && k < bound) begin
      step();
      k++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_released"}, 32'(grant), 32'd0);
  endtask

  initial begin
    int s0;
    int k;
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;

    // Reset, then 50 quiet cycles.
    do_reset(3);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    repeat (50) begin
      step();
      chk("quiet_start", 32'(tx_start), 32'd0);
      chk("quiet_grant", 32'(grant), 32'd0);
      chk("quiet_ready", 32'(ready_seen), 32'd0);
    end

    // Single-byte message from requester 1: exact latency.
    rq[1].push_back({1'b1, 8'h35});
    model_build();
    step();
    step();
    chk("t2_grant_c1", 32'(grant), 32'b010);
    chk("t2_ready_c1", 32'(ready_seen), 32'b010);
    step();
    chk("t2_start_c2", 32'(tx_start), 32'd1);
    chk("t2_data_c2", 32'(tx_data), 32'h35);
    repeat (11) step();
    chk("t2_grant_c13", 32'(grant), 32'b010);
    step();
    chk("t2_grant_c14", 32'(grant), 32'd0);

    // "12\r" from requester 0 while requester 2 waits.
    do_reset(2);
    rq[0].push_back({1'b0, 8'h31});
    rq[0].push_back({1'b0, 8'h32});
    rq[0].push_back({1'b1, 8'h0D});
    rq[2].push_back({1'b1, 8'h41});
    model_build();
    drain("t3", 200);

    // All requesters continuously valid with 1-byte messages.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'hA0 + 16 * r + i)});
    model_build();
    drain("t4", 300);

    // Reset during WAIT_DONE of byte 2 of 3.
    rq[0].push_back({1'b0, 8'hB1});
    rq[0].push_back({1'b0, 8'hB2});
    rq[0].push_back({1'b1, 8'hB3});
    model_build();
    s0 = n_starts;
    k  = 0;
    while (n_starts < s0 + 2 && k < 100) begin step(); k++; end
    chk("t5_second_start", 32'(n_starts - s0), 32'd2);
    step();
    step();
    reset = 1'b1;
    clear_env();
    rq[1].push_back({1'b1, 8'h55});
    model_build();
    step();
    reset = 1'b0;
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_start", 32'(tx_start), 32'd0);
    chk("t5_rst_data", 32'(tx_data), 32'h00);
    chk("t5_rst_ready", 32'(ready_seen), 32'd0);
    chk("t5_frame_inflight", 32'(tx_busy), 32'd1);
    drain("t5", 100);

`ifdef ARB_TIMEOUT_EN
    // Requester 0 stalls inside its message; requester 1 waits behind it.
    tmo_phase = 1'b1;
    rq[0].push_back({1'b0, 8'hC1});
    exp_q.push_back({3'd0, 8'hC1});
    s0 = n_starts;
    k  = 0;
    while (n_starts == s0 && k < 50) begin step(); k++; end
    chk("t6_first_start", 32'(n_starts - s0), 32'd1);
    rq[1].push_back({1'b1, 8'hC2});
    exp_q.push_back({3'd1, 8'hC2});
    repeat (27) step();
    chk("t6_err_before", 32'(err_timeout), 32'd0);
    chk("t6_lock_held", 32'(grant), 32'b001);
    step();
    chk("t6_err_pulse", 32'(err_timeout), 32'd1);
    chk("t6_grant_clear", 32'(grant), 32'd0);
    step();
    chk("t6_err_one_cycle", 32'(err_timeout), 32'd0);
    chk("t6_next_grant", 32'(grant), 32'b010);
    tmo_phase = 1'b0;
    in_msg    = '0;
    drain("t6", 100);
`endif

    // Randomized multi-byte messages with in-message valid gaps.
    do_reset(2);
    gaps_en = 1'b1;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < N; i++) begin
        int nm;
        nm = int'($urandom_range(3, 1));
        for (int m = 0; m < nm; m++) begin
          int len;
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      model_build();
      drain("rand", 3000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
